// File: rtl/use_stream_packer_if.sv
// Record-in / packed-word-out bus of use_stream_packer.
// slave is the packer side, master is the record source plus word sink.
interface use_stream_packer_if #(
  parameter int unsigned DATA_BUS_WIDTH_BYTES = 8,
  parameter int unsigned MAX_USE_BYTES        = 38
);
  logic [MAX_USE_BYTES*8-1:0]        use_in;
  logic [5:0]                        use_len;
  logic                              use_valid;
  logic                              use_ready;
  logic                              flush_in;
  logic [DATA_BUS_WIDTH_BYTES*8-1:0] data_out;
  logic                              data_out_valid;
  logic [3:0]                        data_out_bytes;
  logic                              data_out_ready;
  logic                              idle_out;
  logic                              err_out;
  logic [7:0]                        err_count;

  modport master (
    output use_in, use_len, use_valid, flush_in, data_out_ready,
    input  use_ready, data_out, data_out_valid, data_out_bytes, idle_out, err_out, err_count
  );

  modport slave (
    input  use_in, use_len, use_valid, flush_in, data_out_ready,
    output use_ready, data_out, data_out_valid, data_out_bytes, idle_out, err_out, err_count
  );
endinterface

// File: rtl/use_stream_packer.sv
// Packs variable-length records back-to-back onto a fixed-width byte stream.
// Define USE_PACKER_FORMAT_CHECK_EN to also drop records lacking the variable-field delimiter.
module use_stream_packer #(
  parameter int unsigned DATA_BUS_WIDTH_BYTES    = 8,
  parameter int unsigned MAX_USE_BYTES           = 38,
  parameter int unsigned MIN_USE_BYTES           = 19,
  parameter int unsigned FIXEDFIELD_LENGTH_BYTES = 17,
  parameter logic [7:0]  VARIABLEFIELD_DELIMITER = 8'h2C,
  parameter logic [7:0]  PAD_BYTE                = 8'h00
) (
  input logic                clk,
  input logic                reset,
  use_stream_packer_if.slave bus
);

  localparam int unsigned W        = DATA_BUS_WIDTH_BYTES;
  localparam int unsigned BufBytes = MAX_USE_BYTES + W - 1;
  localparam int unsigned BufBits  = BufBytes * 8;
  localparam int unsigned FillW    = $clog2(BufBytes + 1);

`ifdef USE_PACKER_FORMAT_CHECK_EN
  localparam bit FormatCheck = 1'b1;
`else
  localparam bit FormatCheck = 1'b0;
`endif

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e               state_q, state_d;
  logic [BufBits-1:0]   buf_q, buf_d;
  logic [FillW-1:0]     fill_q, fill_d;
  logic                 armed_q;
  logic                 err_q, err_d;
  logic [7:0]           err_cnt_q, err_cnt_d;

  logic                       final_word, out_valid, ready, accept, transfer;
  logic                       len_ok, delim_hit, write_ok;
  logic [FillW-1:0]           out_bytes;
  logic [MAX_USE_BYTES*8-1:0] rec_bytes;
  logic [W*8-1:0]             data_out_w;

  always_comb begin
    final_word = (state_q == StFlush) && (fill_q != '0) && (fill_q < FillW'(W));
    out_valid  = (fill_q >= FillW'(W)) || ((state_q == StFlush) && (fill_q != '0));
    out_bytes  = final_word ? fill_q : FillW'(W);
    ready      = armed_q && (state_q == StRun) && (fill_q < FillW'(W));
    accept     = bus.use_valid && ready;
    transfer   = out_valid && bus.data_out_ready;
    len_ok     = (bus.use_len >= 6'(MIN_USE_BYTES)) && (bus.use_len <= 6'(MAX_USE_BYTES));
    write_ok   = len_ok && (!FormatCheck || delim_hit);
  end

  // Zero bytes past use_len so the OR-merge below leaves the free tail of the buffer clear.
  always_comb begin
    rec_bytes = '0;
    delim_hit = 1'b0;
    for (int unsigned i = 0; i < MAX_USE_BYTES; i++) begin
      if (i < 32'(bus.use_len)) begin
        rec_bytes[i*8 +: 8] = bus.use_in[i*8 +: 8];
      end
      if (i + FIXEDFIELD_LENGTH_BYTES + 1 == 32'(bus.use_len)) begin
        delim_hit = (bus.use_in[i*8 +: 8] == VARIABLEFIELD_DELIMITER);
      end
    end
  end

  // Accept only happens with fill < W and transfer only with fill >= W (or in flush),
  // so at most one of them updates the buffer in any cycle.
  always_comb begin
    buf_d     = buf_q;
    fill_d    = fill_q;
    state_d   = state_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    if (accept) begin
      if (write_ok) begin
        buf_d  = buf_q | (BufBits'(rec_bytes) << {fill_q, 3'b000});
        fill_d = fill_q + FillW'(bus.use_len);
      end else begin
        err_d = 1'b1;
        if (err_cnt_q != 8'hFF) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
      end
    end else if (transfer) begin
      buf_d  = buf_q >> {out_bytes, 3'b000};
      fill_d = fill_q - out_bytes;
    end
    case (state_q)
      StRun:   if (bus.flush_in && (fill_q != '0)) state_d = StFlush;
      StFlush: if (fill_d == '0) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StRun;
      buf_q     <= '0;
      fill_q    <= '0;
      armed_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      fill_q    <= fill_d;
      armed_q   <= 1'b1;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    data_out_w = '0;
    for (int unsigned k = 0; k < W; k++) begin
      data_out_w[k*8 +: 8] = (final_word && (k >= 32'(fill_q))) ? PAD_BYTE : buf_q[k*8 +: 8];
    end
  end

  assign bus.use_ready      = ready;
  assign bus.data_out       = data_out_w;
  assign bus.data_out_valid = out_valid;
  assign bus.data_out_bytes = 4'(out_bytes);
  assign bus.idle_out       = armed_q && (fill_q == '0) && (state_q == StRun);
  assign bus.err_out        = err_q;
  assign bus.err_count      = err_cnt_q;

endmodule

// File: tb/tb_use_stream_packer.sv
// Randomized bench for use_stream_packer against a byte-queue reference model.
// The model tracks bytes owed downstream, flush intent, arming and the drop counter.
module tb_use_stream_packer;

  localparam int unsigned W    = 8;
  localparam int unsigned MAXB = 38;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  use_stream_packer_if #(.DATA_BUS_WIDTH_BYTES(W), .MAX_USE_BYTES(MAXB)) bus ();

  use_stream_packer dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [7:0]  exp_q[$];
  bit          flushing_m = 1'b0;
  bit          armed_m    = 1'b0;
  bit          err_pend   = 1'b0;
  int unsigned errcnt_m   = 0;
  int unsigned words_full = 0;
  int unsigned words_part = 0;
  int unsigned last_bytes = 0;
  int unsigned bytes_tot  = 0;

  int          m_sz, m_eb, m_len;
  bit          m_ev, m_ok, m_new_err;
  logic [63:0] m_word;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        flushing_m = 1'b0;
        armed_m    = 1'b0;
        err_pend   = 1'b0;
        errcnt_m   = 0;
        check_eq("rst_use_ready", bus.use_ready, 0);
        check_eq("rst_valid", bus.data_out_valid, 0);
        check_eq("rst_data", bus.data_out, 0);
        check_eq("rst_bytes", bus.data_out_bytes, W);
        check_eq("rst_idle", bus.idle_out, 0);
        check_eq("rst_err_out", bus.err_out, 0);
        check_eq("rst_err_count", bus.err_count, 0);
      end else begin
        m_sz = exp_q.size();
        m_ev = (m_sz >= W) || (flushing_m && m_sz > 0);
        m_eb = (flushing_m && m_sz > 0 && m_sz < W) ? m_sz : W;
        check_eq("valid", bus.data_out_valid, m_ev);
        check_eq("bytes", bus.data_out_bytes, m_eb);
        check_eq("use_ready", bus.use_ready, armed_m && !flushing_m && m_sz < W);
        check_eq("idle", bus.idle_out, armed_m && m_sz == 0 && !flushing_m);
        check_eq("err_out", bus.err_out, err_pend);
        check_eq("err_count", bus.err_count, errcnt_m);
        if (m_ev) begin
          m_word = '0;
          for (int k = 0; k < m_eb; k++) m_word[k*8 +: 8] = exp_q[k];
          check_eq("data_out", bus.data_out, m_word);
        end
        if (bus.data_out_valid && bus.data_out_ready && m_ev) begin
          for (int k = 0; k < m_eb; k++) void'(exp_q.pop_front());
          if (m_eb == W) words_full++;
          else begin
            words_part++;
            last_bytes = m_eb;
          end
          bytes_tot += m_eb;
        end
        m_new_err = 1'b0;
        if (bus.use_valid && bus.use_ready) begin
          m_len = int'(bus.use_len);
          m_ok  = (m_len >= 19) && (m_len <= 38);
`ifdef USE_PACKER_FORMAT_CHECK_EN
          if (m_ok && bus.use_in[(m_len-18)*8 +: 8] != 8'h2C) m_ok = 1'b0;
`endif
          if (m_ok) begin
            for (int i = 0; i < m_len; i++) exp_q.push_back(bus.use_in[i*8 +: 8]);
          end else begin
            m_new_err = 1'b1;
            if (errcnt_m < 255) errcnt_m++;
          end
        end
        err_pend = m_new_err;
        if (flushing_m) flushing_m = (exp_q.size() != 0);
        else            flushing_m = bus.flush_in && (m_sz > 0);
        armed_m = 1'b1;
      end
    end
  end

  // Downstream ready: 0 = always, 1 = pattern 1,0,0,1, 2 = random
  int unsigned rdy_mode = 0;
  int unsigned rdy_cyc  = 0;
  initial begin
    bus.data_out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rdy_cyc++;
      case (rdy_mode)
        0:       bus.data_out_ready = 1'b1;
        1:       bus.data_out_ready = (rdy_cyc % 4 == 0) || (rdy_cyc % 4 == 3);
        default: bus.data_out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic send_rec(input int len, input logic [7:0] b0, input int bad_idx);
    logic [MAXB*8-1:0] d;
    int waited;
    for (int i = 0; i < MAXB; i++) d[i*8 +: 8] = 8'($urandom);
    d[7:0] = b0;
    if (len >= 19 && len <= 38) begin
      d[(len-18)*8 +: 8] = 8'h2C;
      d[(len-1)*8 +: 8]  = 8'h2C;
    end
    if (bad_idx >= 0) d[bad_idx*8 +: 8] = 8'hA9;
    bus.use_in    = d;
    bus.use_len   = 6'(len);
    bus.use_valid = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.use_ready && waited < 1000);
    if (!bus.use_ready) check_eq("use_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.use_valid = 1'b0;
  endtask

  task automatic do_flush();
    int waited;
    @(posedge clk);
    #1 bus.flush_in = 1'b1;
    @(posedge clk);
    #1 bus.flush_in = 1'b0;
    waited = 0;
    while ((exp_q.size() != 0 || flushing_m) && waited < 3000) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check_eq("flush_drained", (exp_q.size() == 0) && !flushing_m, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  int lens[20] = '{27, 21, 21, 24, 31, 19, 26, 23, 33, 33, 31, 19, 19, 20, 29, 19, 30, 19, 20, 21};
  int unsigned w0, p0, b0, e0;
  int waited;

  task automatic snap();
    w0 = words_full;
    p0 = words_part;
    b0 = bytes_tot;
    e0 = errcnt_m;
  endtask

  initial begin
    bus.use_in    = '0;
    bus.use_len   = '0;
    bus.use_valid = 1'b0;
    bus.flush_in  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Twenty-record stream, full throughput
    snap();
    for (int r = 0; r < 20; r++) send_rec(lens[r], 8'(r), -1);
    do_flush();
    check_eq("s1_full_words", words_full - w0, 60);
    check_eq("s1_part_words", words_part - p0, 1);
    check_eq("s1_last_bytes", last_bytes, 5);
    check_eq("s1_total_bytes", bytes_tot - b0, 485);

    // Same stream under 1,0,0,1 backpressure
    rdy_mode = 1;
    snap();
    for (int r = 0; r < 20; r++) send_rec(lens[r], 8'(r), -1);
    do_flush();
    check_eq("s2_full_words", words_full - w0, 60);
    check_eq("s2_total_bytes", bytes_tot - b0, 485);
    rdy_mode = 0;

    // Illegal lengths between two legal records
    snap();
    send_rec(20, 8'h40, -1);
    send_rec(18, 8'h41, -1);
    send_rec(39, 8'h42, -1);
    send_rec(21, 8'h43, -1);
    do_flush();
    check_eq("ill_err_count", bus.err_count, 2);
    check_eq("ill_total_bytes", bytes_tot - b0, 41);

    // Reset while the third word of a 33-byte record is going out
    snap();
    send_rec(33, 8'h50, -1);
    waited = 0;
    while (words_full - w0 < 3 && waited < 200) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check_eq("rst_mid_words", words_full - w0, 3);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    snap();
    send_rec(27, 8'h51, -1);
    do_flush();
    check_eq("post_rst_bytes", bytes_tot - b0, 27);

    // Record missing its delimiter (byte 9 of 27)
    snap();
    send_rec(27, 8'h60, 9);
    do_flush();
`ifdef USE_PACKER_FORMAT_CHECK_EN
    check_eq("fmt_err_count", bus.err_count, e0 + 1);
    check_eq("fmt_bytes", bytes_tot - b0, 0);
`else
    check_eq("fmt_err_count", bus.err_count, e0);
    check_eq("fmt_bytes", bytes_tot - b0, 27);
`endif

    // Random lengths, occasional bad delimiter, random downstream ready
    rdy_mode = 2;
    for (int r = 0; r < 40; r++) begin
      m_len = $urandom_range(17, 40);
      send_rec(m_len, 8'(r), ($urandom_range(0, 7) == 0 && m_len >= 19 && m_len <= 38) ?
               m_len - 18 : -1);
    end
    do_flush();
    rdy_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/use_stream_packer.md
Name: use_stream_packer

Overview:
- Transmit-side counterpart of the StreamElement parser ring.
- Accepts complete variable-length records (USEs, up to MAX_USE_BYTES) one at a time over a ready/valid handshake.
- Packs them back-to-back, with no gaps, onto a DATA_BUS_WIDTH_BYTES-wide byte stream. This is the stream the parser ring consumes.
- Used to regenerate/forward record streams and as the stimulus source for ring-level benches.

Parameters:
- DATA_BUS_WIDTH_BYTES, 8, output bus width in bytes.
- MAX_USE_BYTES, 38, maximum record length in bytes.
- MIN_USE_BYTES, 19, minimum legal record length (FIXEDFIELD_LENGTH_BYTES+2).
- FIXEDFIELD_LENGTH_BYTES, 17, fixed-field length; used only by the optional check.
- VARIABLEFIELD_DELIMITER, 8'h2C, delimiter value; used only by the optional check.
- PAD_BYTE, 8'h00, fill value for unused lanes of a flushed partial word.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low.
- use_in  in  MAX_USE_BYTES*8  record bytes; byte n at bits [n*8+7 -: 8], byte 0 is first on the wire.
- use_len  in  6  record length in bytes.
- use_valid  in  1  record present.
- use_ready  out  1  packer accepts the record this cycle.
- flush_in  in  1  request to drain the residue, including a partial final word.
- data_out  out  DATA_BUS_WIDTH_BYTES*8  packed word; lane k holds wire byte k of the word.
- data_out_valid  out  1  word valid.
- data_out_bytes  out  4  valid lanes in data_out; 1..DATA_BUS_WIDTH_BYTES.
- data_out_ready  in  1  downstream accepts the word.
- idle_out  out  1  buffer empty and FSM in RUN.
- err_out  out  1  one-cycle pulse when a record is dropped.
- err_count  out  8  saturating count of dropped records.

Behaviour:
- Storage: byte buffer of MAX_USE_BYTES+DATA_BUS_WIDTH_BYTES-1 bytes (45 at defaults) and fill count `fill`, 0..45. Buffer byte 0 is the next byte to transmit.
- Reset (asserted low):
  - fill=0, buffer cleared, FSM=RUN, armed=0, err_count=0.
  - Outputs: use_ready=0, data_out_valid=0, data_out=0, data_out_bytes=DATA_BUS_WIDTH_BYTES, err_out=0, idle_out=0.
  - The `armed` flop sets on the first clk after reset release; use_ready and idle_out are gated by `armed`.
- Reset mid-record or mid-flush: all residue is discarded; no partial word is emitted after release.
- FSM states:
  - RUN: use_ready = armed && fill < DATA_BUS_WIDTH_BYTES. Go to FLUSH when flush_in=1 and fill>0. flush_in with fill=0 is ignored.
  - FLUSH: use_ready=0. Full words drain normally. When 0<fill<DATA_BUS_WIDTH_BYTES, the final word is presented with data_out_bytes=fill and lanes >= fill set to PAD_BYTE. On that word's transfer, fill=0 and FSM returns to RUN.
- Accept: on use_valid && use_ready, with legal use_len (MIN_USE_BYTES..MAX_USE_BYTES), bytes 0..use_len-1 are written to buffer[fill..fill+use_len-1]. New fill = fill+use_len.
- Illegal length: the record is still handshaken (use_ready is honoured) but not written. err_out pulses the next cycle; err_count increments, saturating at 255.
- Output (combinational from buffer):
  - data_out = buffer[0..DATA_BUS_WIDTH_BYTES-1].
  - data_out_valid = fill >= DATA_BUS_WIDTH_BYTES, or (FSM==FLUSH && fill>0).
  - data_out_bytes = DATA_BUS_WIDTH_BYTES except on the final flush word.
- Transfer: on data_out_valid && data_out_ready, the buffer shifts down by data_out_bytes and fill decrements by the same amount.
- Accept and transfer are mutually exclusive in a cycle, because use_ready requires fill < DATA_BUS_WIDTH_BYTES. No simultaneous-update case exists.
- Latency: a record accepted at edge N makes its first word valid in the cycle after edge N (one cycle).
- Throughput: one word per cycle while data_out_ready=1.
- Backpressure: data_out_ready=0 holds data_out, data_out_valid and data_out_bytes stable.
- idle_out = armed && fill==0 && FSM==RUN.

Optional Feature:
- Macro: USE_PACKER_FORMAT_CHECK_EN.
- Defined: an accepted record is also dropped (err_out/err_count, as for an illegal length) unless byte[use_len-FIXEDFIELD_LENGTH_BYTES-1]==VARIABLEFIELD_DELIMITER. Other bytes equal to VARIABLEFIELD_DELIMITER, including the last byte, are not checked.
- Undefined: no content check; only the length check applies.

Test Plan:
- Reset release: use_ready=0 in the first cycle, 1 from the second; data_out_valid=0; idle_out=1.
- Twenty records, lengths 27,21,21,24,31,19,26,23,33,33,31,19,19,20,29,19,30,19,20,21; byte 0 = record index; delimiter at len-18; last byte 8'h2C. With data_out_ready=1 then flush_in=1:
  - Exactly 60 full words plus one final word with data_out_bytes=5 and lanes 5..7 = 8'h00; 485 bytes total.
  - The byte sequence matches the concatenation exactly.
  - Looped into a 4-element StreamElement ring, the ring returns all 20 records with correct lengths.
- Backpressure: same stream with data_out_ready toggling 1,0,0,1 repeatedly -> identical byte sequence; word held stable while not ready; use_ready stays 0 whenever fill >= 8.
- Illegal lengths: use_len=18 and use_len=39 -> each handshaken, no bytes emitted, err_out pulses, err_count=2; neighbouring records are unaffected.
- Reset at word 3 of a 33-byte record: no data_out_valid after release, fill=0; the next 27-byte record is packed from lane 0.
- With USE_PACKER_FORMAT_CHECK_EN: a 27-byte record with byte 9 = 8'hA9 is dropped (err_count +1). Without the macro the same record is emitted intact.
